// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory command port: bus IDs, opcodes,
// command-byte field layout and the port state encoding.
package mem_if_pkg;

  localparam logic [1:0] BUS_ID_MEM = 2'd0;
  localparam logic [1:0] BUS_ID_SHA = 2'd1;
  localparam logic [1:0] BUS_ID_AES = 2'd2;

  localparam logic [1:0] OP_RD_KEY  = 2'd0;
  localparam logic [1:0] OP_RD_TEXT = 2'd1;
  localparam logic [1:0] OP_WR_RES  = 2'd2;
  localparam logic [1:0] OP_OTHER   = 2'd3;

  localparam int CMD_ENC_BIT  = 7;
  localparam int CMD_DEST_LSB = 4;
  localparam int CMD_SRC_LSB  = 2;
  localparam int CMD_OP_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CMD,
    ST_XFER,
    ST_ACK_REQ,
    ST_ACK_DONE
  } port_state_t;

  function automatic logic [1:0] cmd_field(input logic [7:0] cmd, input int lsb);
    return cmd[lsb +: 2];
  endfunction

endpackage

// File: rtl/mem_port_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
module mem_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_cmd_port_fifo.sv
// Memory command port: decodes bus commands for this port, collects the
// address, hands the command to the memory FSM and buffers payload both ways.
module mem_cmd_port_fifo
  import mem_if_pkg::*;
#(
  parameter int         ADDR_BYTES   = 3,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [1:0] MEM_ID       = 2'b00,
  parameter int         ACK_ON_WRITE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_bus_valid,
  input  logic                    in_bus_ready,
  input  logic [7:0]              in_bus_data,
  output logic [7:0]              out_bus_data,
  output logic                    out_bus_ready,
  output logic                    out_bus_valid,
  input  logic                    in_ack_bus_owned,
  output logic                    out_ack_bus_request,
  output logic [1:0]              out_ack_bus_id,
  output logic                    out_fsm_valid,
  output logic                    out_fsm_ready,
  output logic [7:0]              out_fsm_data,
  input  logic                    in_fsm_ready,
  input  logic                    in_fsm_valid,
  input  logic [7:0]              in_fsm_data,
  input  logic                    in_fsm_done,
  output logic                    out_fsm_enc_type,
  output logic [1:0]              out_fsm_opcode,
  output logic [8*ADDR_BYTES-1:0] out_address,
  output logic                    out_busy,
  output logic [7:0]              out_drop_count
);

  localparam int ADDR_IDX_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [ADDR_IDX_W-1:0] ADDR_LAST = ADDR_IDX_W'(ADDR_BYTES - 1);

  port_state_t             state;
  logic [7:0]              cmd_q;
  logic                    done_latch;
  logic [ADDR_IDX_W-1:0]   addr_idx;
  logic                    out_en;
  logic [1:0]              in_op;
  logic                    cmd_match;
  logic                    is_write;
  logic [8:0]              drop_sum;

  logic                    fifo_flush;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [7:0]              fifo_din;
  logic [7:0]              fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign in_op     = cmd_field(in_bus_data, CMD_OP_LSB);
  assign cmd_match = (((in_op == OP_RD_KEY) || (in_op == OP_RD_TEXT)) &&
                      (cmd_field(in_bus_data, CMD_DEST_LSB) == MEM_ID)) ||
                     ((in_op == OP_WR_RES) &&
                      (cmd_field(in_bus_data, CMD_SRC_LSB) == MEM_ID));
  assign is_write  = (out_fsm_opcode == OP_WR_RES);
  assign drop_sum  = {1'b0, out_drop_count} + 9'(fifo_count);

  assign out_busy            = (state != ST_IDLE);
  assign out_ack_bus_request = (state == ST_ACK_REQ);
  assign out_ack_bus_id      = (state == ST_ACK_REQ) ? MEM_ID : 2'b00;

  mem_port_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Once the FSM has signalled done, leftover write bytes are dropped rather than offered.
  always_comb begin
    out_bus_ready = 1'b0;
    out_bus_valid = 1'b0;
    out_bus_data  = 8'h00;
    out_fsm_valid = 1'b0;
    out_fsm_ready = 1'b0;
    out_fsm_data  = 8'h00;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_din      = 8'h00;
    fifo_flush    = 1'b0;
    case (state)
      ST_IDLE: out_bus_ready = out_en;
      ST_ADDR: out_bus_ready = 1'b1;
      ST_CMD: begin
        out_fsm_valid = 1'b1;
        out_fsm_data  = cmd_q;
      end
      ST_XFER: begin
        if (is_write) begin
          out_bus_ready = !fifo_full && !done_latch;
          out_fsm_valid = !fifo_empty && !done_latch;
          out_fsm_data  = fifo_dout;
          fifo_din      = in_bus_data;
          fifo_push     = in_bus_valid && !fifo_full && !done_latch;
          fifo_pop      = !fifo_empty && !done_latch && in_fsm_ready;
          fifo_flush    = done_latch;
        end else begin
          out_fsm_ready = !fifo_full;
          out_bus_valid = !fifo_empty;
          out_bus_data  = fifo_dout;
          fifo_din      = in_fsm_data;
          fifo_push     = in_fsm_valid && !fifo_full;
          fifo_pop      = !fifo_empty && in_bus_ready;
        end
      end
      default: ;
    endcase
  end

  // out_en keeps out_bus_ready low in the first cycle after reset so every output reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      cmd_q            <= 8'h00;
      out_fsm_enc_type <= 1'b0;
      out_fsm_opcode   <= 2'b00;
      out_address      <= '0;
      addr_idx         <= '0;
      done_latch       <= 1'b0;
      out_drop_count   <= 8'h00;
      out_en           <= 1'b0;
    end else begin
      out_en <= 1'b1;
      if (state == ST_IDLE) begin
        done_latch <= 1'b0;
      end else if (in_fsm_done) begin
        done_latch <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (in_bus_valid && out_en && cmd_match) begin
            cmd_q            <= in_bus_data;
            out_fsm_enc_type <= in_bus_data[CMD_ENC_BIT];
            out_fsm_opcode   <= in_op;
            addr_idx         <= '0;
            state            <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (in_bus_valid) begin
            out_address[8*addr_idx +: 8] <= in_bus_data;
            if (addr_idx == ADDR_LAST) begin
              state <= ST_CMD;
            end else begin
              addr_idx <= addr_idx + 1'b1;
            end
          end
        end
        ST_CMD: begin
          if (in_fsm_ready) state <= ST_XFER;
        end
        ST_XFER: begin
          if (is_write) begin
            if (done_latch) begin
              out_drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
              state          <= (ACK_ON_WRITE != 0) ? ST_ACK_REQ : ST_IDLE;
            end
          end else if (done_latch && fifo_empty && !in_fsm_valid) begin
            state <= ST_ACK_REQ;
          end
        end
        ST_ACK_REQ: begin
          if (in_ack_bus_owned) state <= ST_ACK_DONE;
        end
        ST_ACK_DONE: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_cmd_port_fifo.md
Name: mem_cmd_port_fifo

Overview:
- Parametrised successor to the memory command port. It sits between the shared 8-bit crypto data bus and the memory transaction FSM.
- Decodes command bytes addressed to memory and collects a parametrised-length address. It then hands the command to the FSM and moves payload through an elastic FIFO in either direction.
- Signals read completion on the ack bus, and optionally write completion.

Parameters:
- ADDR_BYTES, 3: address bytes following the command byte; out_address width = 8*ADDR_BYTES.
- FIFO_DEPTH, 4: payload FIFO entries (power of two, >=2).
- MEM_ID, 2'b00: this port's bus ID.
- ACK_ON_WRITE, 0: 1 = WR_RES completion also issues an ack-bus request.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_bus_valid  in  1  bus byte valid
- in_bus_ready  in  1  bus consumer ready for out_bus_data
- in_bus_data  in  8  bus byte
- out_bus_data  out  8  read payload byte to bus
- out_bus_ready  out  1  port accepts in_bus_data
- out_bus_valid  out  1  out_bus_data valid
- in_ack_bus_owned  in  1  ack bus granted
- out_ack_bus_request  out  1  ack bus request
- out_ack_bus_id  out  2  ack source ID (= MEM_ID)
- out_fsm_valid  out  1  command/payload byte to FSM valid
- out_fsm_ready  out  1  port accepts in_fsm_data
- out_fsm_data  out  8  command byte, then write payload
- in_fsm_ready  in  1  FSM accepts out_fsm_data
- in_fsm_valid  in  1  FSM read byte valid
- in_fsm_data  in  8  FSM read byte
- in_fsm_done  in  1  FSM transaction complete pulse
- out_fsm_enc_type  out  1  command bit 7
- out_fsm_opcode  out  2  command bits [1:0]
- out_address  out  8*ADDR_BYTES  collected address
- out_busy  out  1  state != IDLE
- out_drop_count  out  8  saturating count of write bytes flushed by early done

Behaviour:

Reset and handshake rules
- Reset (rst high at clk edge, any state): all outputs 0, FIFO empty, done latch 0, state IDLE.
- A transfer occurs when valid&&ready are high on a clk edge.

Command byte decode (fields)
- bit 7 = enc, [5:4] = dest, [3:2] = src, [1:0] = opcode.
- Opcodes: RD_KEY=0, RD_TEXT=1, WR_RES=2, OTHER=3.

IDLE
- out_bus_ready=1. The byte is consumed every cycle it is valid.
- Accept RD_KEY/RD_TEXT when dest==MEM_ID; accept WR_RES when src==MEM_ID.
- On accept: latch the command byte, opcode and enc, then go to ADDR.
- Non-matching bytes and OTHER are consumed and ignored.
- in_fsm_done is ignored here; the done latch is held at 0.

ADDR
- out_bus_ready=1.
- Each accepted byte k (0..ADDR_BYTES-1) is written to out_address[8k+7:8k], LSB byte first.
- After byte ADDR_BYTES-1, go to CMD on the next cycle.

CMD
- out_fsm_valid=1, out_fsm_data = latched command byte, both held stable until in_fsm_ready.
- On handshake, go to XFER the next cycle.

XFER, write (opcode WR_RES): bus -> FIFO -> FSM
- out_bus_ready = !full && !done_latch.
- out_fsm_valid = !empty, out_fsm_data = FIFO head (first-word fall-through).
- Push and pop may occur in the same cycle.
- On done_latch:
  - flush the FIFO and add its occupancy to out_drop_count, saturating at 255;
  - then go to ACK_REQ if ACK_ON_WRITE, else IDLE.

XFER, read (RD_KEY/RD_TEXT): FSM -> FIFO -> bus
- out_fsm_ready = !full; out_bus_valid = !empty; out_bus_data = head.
- When done_latch && empty && !in_fsm_valid, go to ACK_REQ.
- Read bytes are never dropped.

Done latch
- Set by in_fsm_done in any non-IDLE state, including ADDR and CMD.
- Cleared in IDLE.
- A done arriving before XFER is honoured on XFER entry.

ACK_REQ
- out_ack_bus_request=1, out_ack_bus_id=MEM_ID.
- On in_ack_bus_owned, go to ACK_DONE.

ACK_DONE
- Request dropped, then go to IDLE.

Boundary conditions
- FIFO full: the producer stalls (no overwrite).
- FIFO empty: the consumer sees valid=0.
- Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.

Latency
- Command-to-CMD valid: ADDR_BYTES+1 cycles after the command byte handshake, with a back-to-back bus.
- Payload: one cycle through the FIFO.

Decomposition:
- Package mem_if_pkg:
  - bus IDs MEM/SHA/AES;
  - opcode constants;
  - command-byte field positions;
  - state encoding (IDLE, ADDR, CMD, XFER, ACK_REQ, ACK_DONE).
- Sub-module mem_port_fifo: synchronous FWFT FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop, full/empty, count, synchronous flush.
  - Used once; the data direction is selected by the opcode.

Test Plan:
- Read, ADDR_BYTES=3: cmd 0x01 (dest 0), addr 0x56,0x34,0x12 -> out_address=0x123456, out_fsm_data=0x01 with opcode 1; FSM sends 5 bytes with in_bus_ready toggling -> 5 bytes delivered in order; done, then ack request; owned -> IDLE.
- Write: cmd 0x02 (src 0), 8 payload bytes, FSM ready 1 cycle in 3 -> FIFO fills to 4 and out_bus_ready drops; all 8 bytes reach the FSM in order; ACK_ON_WRITE=0 -> IDLE with no ack request.
- Early write done: 2 bytes buffered when in_fsm_done pulses -> FIFO flushed, out_drop_count=2, IDLE next cycle.
- Filtering: bytes 0x11 (dest 1, opcode 1), 0x03 (OTHER) and 0x06 (WR_RES, src 1) -> stays IDLE, out_busy=0.
- Done during CMD, with in_fsm_ready low for 3 cycles -> after handshake, XFER with empty FIFO goes to ACK_REQ within 1 cycle.
- rst asserted mid-XFER with FIFO at 3 entries -> next edge: all outputs 0, state IDLE; a following command runs normally.
